// File: rtl/instruction_fetch_if.sv
// rtl/instruction_fetch_if.sv - instruction memory read port and fetch-to-decode bundle.
// The master side is the fetch stage; the slave side models memory plus decode.
interface instruction_fetch_if;
  logic [31:0] imem_address;
  logic [31:0] imem_instruction;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instruction;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;

  modport master (
    output imem_address,
    input  imem_instruction,
    output out_valid,
    input  out_ready,
    output out_instruction,
    output out_pc,
    output out_pc_plus4
  );

  modport slave (
    input  imem_address,
    output imem_instruction,
    input  out_valid,
    output out_ready,
    input  out_instruction,
    input  out_pc,
    input  out_pc_plus4
  );
endinterface

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch stage: PC, registered instruction bundle, redirect/halt control.
// Memory read is combinational, so a fetch captures imem_instruction on the same edge the PC advances.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  instruction_fetch_if.master bus,
  input  logic                redirect_valid,
  input  logic [31:0]         redirect_target,
  input  logic                halt,
  output logic                halted,
  output logic                misalign_err,
  output logic [CNT_W-1:0]    fetch_count
);

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic               valid_q, valid_d;
  logic [31:0]        instr_q, instr_d;
  logic [31:0]        opc_q, opc_d;
  logic [31:0]        opc4_q, opc4_d;
  logic               mis_q, mis_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= '0;
      opc_q   <= '0;
      opc4_q  <= '0;
      mis_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      opc_q   <= opc_d;
      opc4_q  <= opc4_d;
      mis_q   <= mis_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    opc_d   = opc_q;
    opc4_d  = opc4_q;
    mis_d   = 1'b0;
    cnt_d   = cnt_q;
    fire    = (state_q == ST_RUN) && !halt && !redirect_valid && (!valid_q || bus.out_ready);

    // A redirect always lands in RUN; a still-high halt re-enters HALTED one cycle later.
    unique case (state_q)
      ST_RUN:    if (halt && !redirect_valid) state_d = ST_HALTED;
      ST_HALTED: if (!halt || redirect_valid) state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase

    if (redirect_valid) begin
      pc_d    = {redirect_target[31:2], 2'b00};
      valid_d = 1'b0;
      mis_d   = |redirect_target[1:0];
    end else if (fire) begin
      instr_d = bus.imem_instruction;
      opc_d   = pc_q;
      opc4_d  = pc_q + 32'd4;
      valid_d = 1'b1;
      pc_d    = pc_q + 32'd4;
      cnt_d   = cnt_q + CNT_W'(1);
    end else if (valid_q && bus.out_ready) begin
      valid_d = 1'b0;
    end
  end

  assign bus.imem_address    = pc_q;
  assign bus.out_valid       = valid_q;
  assign bus.out_instruction = instr_q;
  assign bus.out_pc          = opc_q;
  assign bus.out_pc_plus4    = opc4_q;
  assign halted              = (state_q == ST_HALTED);
  assign misalign_err        = mis_q;
  assign fetch_count         = cnt_q;

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage that acts as the reader of `instruction_memory`: drives the word address and captures the returned instruction.
- Holds the program counter and presents one registered instruction at a time to decode through a valid/ready handshake.
- Supports control-flow redirects (branch/jump), halt/resume and a fetch counter.
- Sits between `instruction_memory` (combinational read, same-cycle data) and the decode/control logic.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset; must be word aligned.
- CNT_W, 16, width of `fetch_count`.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_address  output  32  address to `instruction_memory`; combinationally equal to the PC register.
- imem_instruction  input  32  instruction read from `instruction_memory` for `imem_address`, valid in the same cycle.
- redirect_valid  input  1  single-cycle request to load a new PC.
- redirect_target  input  32  new PC for a redirect.
- halt  input  1  stop issuing fetches while high.
- out_valid  output  1  `out_*` bundle holds an unconsumed instruction.
- out_ready  input  1  decode accepts the bundle this cycle.
- out_instruction  output  32  registered instruction.
- out_pc  output  32  address the instruction was fetched from.
- out_pc_plus4  output  32  `out_pc + 4`, modulo 2^32.
- halted  output  1  high while the state machine is in HALTED.
- misalign_err  output  1  one-cycle pulse when a redirect target had nonzero bits [1:0].
- fetch_count  output  CNT_W  number of fetches fired, modulo 2^CNT_W.

Behaviour:
- Reset (`rst` high at clock edge) overrides every other input, including mid-transfer.
  - PC = RESET_PC, state = RUN.
  - All `out_*` = 0, `out_valid` = 0, `misalign_err` = 0, `fetch_count` = 0, `halted` = 0.
- States:
  - RUN: fetching. HALTED: no fetches.
  - RUN -> HALTED when `halt` = 1 and `redirect_valid` = 0.
  - HALTED -> RUN when `halt` = 0, or on any `redirect_valid`.
- Fire condition: `fire = (state == RUN) && !halt && !redirect_valid && (!out_valid || out_ready)`.
- On fire:
  - `out_instruction <= imem_instruction`, `out_pc <= PC`, `out_pc_plus4 <= PC + 4`.
  - `out_valid <= 1`, `PC <= PC + 4`, `fetch_count` increments.
  - Latency: instruction at PC appears on `out_*` one cycle after `imem_address` = PC.
- Handshake:
  - A transfer occurs when `out_valid && out_ready`.
  - Accept with no fire in the same cycle: `out_valid <= 0`.
  - Accept and fire in the same cycle: back-to-back, `out_valid` stays 1 with the new bundle. Sustained throughput is 1 instruction/cycle while `out_ready` = 1.
  - `out_valid && !out_ready`: every `out_*` and the PC hold unchanged (stall). `out_valid` never drops without acceptance, except on redirect or reset.
- Redirect (priority just below reset):
  - `PC <= {redirect_target[31:2], 2'b00}`; `out_valid <= 0` (flush, regardless of `out_ready`); no fire that cycle; state <= RUN even if `halt` = 1.
  - If `halt` is still high on the next cycle, state re-enters HALTED.
  - `misalign_err <= |redirect_target[1:0]`; otherwise `misalign_err` is 0 every cycle.
- Halt:
  - While halted, PC holds and no fetch fires.
  - A pending `out_valid` bundle remains visible and may still be accepted.
- Wrap-around:
  - PC 32'hFFFFFFFC + 4 = 32'h00000000; `out_pc_plus4` wraps the same way.
  - `fetch_count` wraps to 0 after all ones.
- Inputs `imem_instruction`, `out_ready` and `halt` are don't-care during reset.

Test Plan:
- Reset then sequential fetch: memory word0 = 32'h0004A000, word1 = 32'h10E4FFFC, word2 = 32'h00A4380A; `out_ready` = 1. Required: cycles 1–3 show `out_instruction` = those words with `out_pc` = 0, 4, 8; `fetch_count` = 3; `imem_address` = 12 on cycle 3.
- Stall: `out_ready` = 0 for 3 cycles with `out_pc` = 4 valid. Required: `out_*`, `imem_address` = 8 and `fetch_count` all constant. When `out_ready` rises, `out_pc` = 8 the next cycle.
- Redirect with a pending unaccepted bundle: `redirect_target` = 32'h00000042, `out_ready` = 0. Required: next cycle `out_valid` = 0, `imem_address` = 32'h00000040, `misalign_err` = 1 for exactly one cycle; following cycle `out_pc` = 32'h40.
- Halt and resume: `halt` = 1 at PC = 16 with `out_valid` = 1. Required: `halted` = 1, bundle accepted once then `out_valid` = 0, PC stays 16. `halt` = 0 -> fetch from 16 resumes; `redirect_valid` + `halt` together -> PC loaded, `halted` = 0 for that cycle.
- Wrap: `redirect_target` = 32'hFFFFFFFC then two fetches. Required: `out_pc` = 32'hFFFFFFFC with `out_pc_plus4` = 0, then `out_pc` = 0.
- Reset mid-stall: `rst` = 1 while `out_valid` = 1 and `out_ready` = 0. Required: next cycle `out_valid` = 0, PC = RESET_PC, `fetch_count` = 0.
